// File: rtl/riscv_defs.sv
// Shared RV32I load/store op codes and LSU FSM state encoding.
package riscv_defs;

    localparam logic [6:0] OH_LB  = 7'd11;
    localparam logic [6:0] OH_LH  = 7'd12;
    localparam logic [6:0] OH_LW  = 7'd13;
    localparam logic [6:0] OH_LBU = 7'd14;
    localparam logic [6:0] OH_LHU = 7'd15;
    localparam logic [6:0] OH_SB  = 7'd16;
    localparam logic [6:0] OH_SH  = 7'd17;
    localparam logic [6:0] OH_SW  = 7'd18;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    function automatic logic is_load(input logic [6:0] op);
        return (op >= OH_LB) && (op <= OH_LHU);
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return (op >= OH_SB) && (op <= OH_SW);
    endfunction

    function automatic logic misaligned(input logic [6:0] op, input logic [1:0] lane);
        case (op)
            OH_LH, OH_LHU, OH_SH: return lane[0];
            OH_LW, OH_SW:         return lane != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane placement for stores and lane select plus sign/zero extension for loads.
// Purely combinational; no latency, no flow control.
module lsu_align
    import riscv_defs::*;
(
    input  logic [6:0]  st_oh,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [6:0]  ld_oh,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        case (st_oh)
            OH_SB: begin
                wstrb = 4'b0001 << st_lane;
                wdata = {4{st_data[7:0]}};
            end
            OH_SH: begin
                wstrb = 4'b0011 << st_lane;
                wdata = {2{st_data[15:0]}};
            end
            OH_SW: begin
                wstrb = 4'b1111;
                wdata = st_data;
            end
            default: ;
        endcase
    end

    // Addressed byte/half moved down to bit 0; LW is always lane 0 so it passes through.
    assign shifted = rdata >> {ld_lane, 3'b000};

    always_comb begin
        case (ld_oh)
            OH_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            OH_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            OH_LBU:  ld_data = {24'h0, shifted[7:0]};
            OH_LHU:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding req/gnt/rvalid transaction, writeback of load data.
// Latency: store 2 cycles, load 3 cycles minimum; stalls execute via hold2ctrl until back in IDLE.
module lsu
    import riscv_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ins_valid,
    input  logic [6:0]  oh,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr2lsu,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_wen2reg,
    output logic        hold2ctrl,
    output logic        misalign
);

    state_t      state;
    logic [31:0] ea;
    logic        mem_op;
    logic        bad_align;
    logic        accept;
    logic [6:0]  oh_q;
    logic [1:0]  lane_q;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign ea        = base + offset;
    assign mem_op    = is_load(oh) | is_store(oh);
    assign bad_align = misaligned(oh, ea[1:0]);
    assign accept    = (state == IDLE) & ins_valid & mem_op & ~bad_align;
    assign hold2ctrl = accept | (state != IDLE);

    lsu_align u_align (
        .st_oh   (oh),
        .st_lane (ea[1:0]),
        .st_data (store_data),
        .wstrb   (st_wstrb),
        .wdata   (st_wdata),
        .ld_oh   (oh_q),
        .ld_lane (lane_q),
        .rdata   (mem_rdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
            rd_addr    <= 5'd0;
            rd_data    <= 32'h0;
            rd_wen2reg <= 1'b0;
            misalign   <= 1'b0;
            oh_q       <= 7'd0;
            lane_q     <= 2'b00;
        end else begin
            rd_wen2reg <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ins_valid && mem_op && bad_align) begin
                        misalign <= 1'b1;
                    end else if (accept) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store(oh);
                        mem_addr  <= {ea[31:2], 2'b00};
                        mem_wstrb <= st_wstrb;
                        mem_wdata <= st_wdata;
                        rd_addr   <= rd_addr2lsu;
                        oh_q      <= oh;
                        lane_q    <= ea[1:0];
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rd_data    <= ld_data;
                        rd_wen2reg <= (rd_addr != 5'd0);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage in the RV32I core. It accepts load and store operations (one-hot codes 11–18) from execute, computes the effective address, and runs one transaction at a time on a single-outstanding request/grant/response data bus. It also handles byte-lane alignment and sign/zero extension, and writes load results back to the register file. While an access is in flight it stalls the pipeline through ctrl.

## Interface
Parameters:
- none (RV32I, 32-bit data/address fixed)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- ins_valid  in  1  execute presents an operation this cycle
- oh  in  7  operation code: 11 LB, 12 LH, 13 LW, 14 LBU, 15 LHU, 16 SB, 17 SH, 18 SW; any other value is not a memory op
- base  in  32  rs1 value
- offset  in  32  sign-extended I/S immediate
- store_data  in  32  rs2 value
- rd_addr2lsu  in  5  load destination register
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wstrb  out  4  byte enables, stores only; 0 for loads
- mem_wdata  out  32  store data replicated/shifted into lanes
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word
- rd_addr  out  5  writeback address
- rd_data  out  32  writeback data
- rd_wen2reg  out  1  writeback enable, one-cycle pulse
- hold2ctrl  out  1  stall request to ctrl
- misalign  out  1  one-cycle pulse on a misaligned access

## Operation
- Effective address: ea = base + offset, mod 2^32; lane = ea[1:0].
- Misaligned cases: LH/LHU/SH with ea[0]=1; LW/SW with ea[1:0]≠0. These are not issued to the bus. misalign pulses on the next cycle, with no writeback and no stall beyond the presenting cycle.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on ins_valid & memory op & aligned, register ea, oh, rd_addr and lane-shifted store data/strobe, then go to REQ.
  - REQ: mem_req=1 and the bus fields are held stable until mem_gnt. On gnt, a store goes to IDLE and a load goes to WAIT.
  - WAIT: on mem_rvalid, select and extend the data, register it into rd_data with rd_wen2reg=1 for one cycle, then go to IDLE.
- Store strobes: SB gives 4'b0001<<lane with data {4{b}}; SH gives 4'b0011<<lane with data {2{h}}; SW gives 4'b1111.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- A load with rd=0 still performs the bus access but never asserts rd_wen2reg.
- hold2ctrl = (IDLE & ins_valid & memory op & aligned) | (state≠IDLE).
- mem_rvalid is ignored outside WAIT. Non-memory oh values are ignored.

## Timing
- Reset (async, immediate) forces: state IDLE; mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr, rd_addr, rd_data, rd_wen2reg, hold2ctrl (registered part) and misalign all 0.
- Reset mid-transaction abandons it; a late rvalid after reset is ignored.
- Accept at edge N. mem_req is high from cycle N+1.
- Store with gnt in cycle N+1: back in IDLE at N+2, with hold low in N+2. Minimum store occupancy is 2 cycles.
- Load with gnt in N+1 and rvalid in N+2: rd_wen2reg is high in N+3, and hold is low in N+3. Minimum load latency is 3 cycles to writeback.
- gnt and rvalid in the same cycle as the request is not allowed by the bus protocol; the response is earliest the cycle after gnt.
- No new operation is accepted until IDLE. Execute holds its inputs while hold2ctrl=1.

## Structure
- Shared package riscv_defs holds the oh code constants (OH_LB=11 … OH_SW=18) and the FSM state enum.
- One combinational sub-module, lsu_align, holds lane/strobe generation for stores and the byte/half select plus extension for loads.

## Test plan
- SW: base=0x100, offset=4, data 0xDEADBEEF, gnt in first REQ cycle. Expect mem_addr=0x104, wstrb=1111, wdata=0xDEADBEEF, one-cycle mem_req, hold for 2 cycles.
- SB: ea=0x203, data 0x000000A5. Expect mem_addr=0x200, wstrb=1000, wdata=0xA5A5A5A5.
- LB: ea=0x301, rdata=0x0000_80_00, gnt delayed 2 cycles, rvalid 3 cycles later, rd=5. Expect rd_data=0xFFFFFF80, rd_addr=5, and one rd_wen pulse the cycle after rvalid. LBU on the same data expects 0x00000080.
- LW at ea=0x402. Expect misalign pulse, no mem_req, no rd_wen. LH at 0x402 expects a normal access with rdata[31:16] selected.
- Load to rd=0. Expect the bus access to occur and rd_wen2reg to stay 0.
- rst_n low while in WAIT, then rvalid arrives after release. Expect all outputs 0 immediately, state IDLE, and the late rvalid ignored.
